// File: rtl/seg7_pkg.sv
//============================================================================
// Module  : seg7_pkg
// Brief   : Shared types and constants for the 4-digit 7-segment scan block.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] digit_sel_t;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    DEAD = 2'd1,
    ON   = 2'd2
  } scan_state_t;

  localparam logic [NUM_DIGITS-1:0] ANODE_ALL_OFF = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/seg7_prescaler.sv
//============================================================================
// Module  : seg7_prescaler
// Brief   : Digit-period phase counter, 0..DIV-1, with terminal-count flag
//           and synchronous clear.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module seg7_prescaler #(
  parameter int DIV   = 50000,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;

  assign w_tc  = (r_cnt == C_LAST);
  assign o_cnt = r_cnt;
  assign o_tc  = w_tc;

  // Count up through the digit period; wrap at the terminal count, clear on demand.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || w_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
//============================================================================
// Module  : seg7_scan_ctrl
// Brief   : Time-multiplexing scan controller for a 4-digit 7-segment display.
//           Drives the segment-mux select, active-low anodes with dead time
//           between digits, per-digit blanking and a slot-start tick.
//           Optional macro SEG7_SCAN_DIM_EN adds i_bright[3:0] PWM dimming.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIV         = 50000,
  parameter int DEAD_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [NUM_DIGITS-1:0] i_blank_mask,
`ifdef SEG7_SCAN_DIM_EN
  input  logic [3:0]            i_bright,
`endif
  output logic [1:0]            o_ctrl,
  output logic [NUM_DIGITS-1:0] o_anode_n,
  output logic                  o_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  // Last DEAD cycle; unused when there is no dead time.
  localparam logic [CNT_W-1:0] C_DEAD_LAST =
    (DEAD_CYCLES == 0) ? '0 : CNT_W'(DEAD_CYCLES - 1);

  scan_state_t           r_state;
  scan_state_t           w_state_nxt;
  digit_sel_t            r_ctrl;
  digit_sel_t            w_ctrl_nxt;
  logic [NUM_DIGITS-1:0] r_anode_n;
  logic [NUM_DIGITS-1:0] w_anode_nxt;
  logic                  r_tick;
  logic                  w_tick_nxt;
  logic [CNT_W-1:0]      w_cnt;
  logic                  w_tc;
  logic                  w_clr;
  logic                  w_lit;

  // Counter is held at zero while off and cleared on any disable.
  assign w_clr = ~i_en | (r_state == OFF);

  seg7_prescaler #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_prescaler (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_clr),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );

`ifdef SEG7_SCAN_DIM_EN
  localparam int W_W = CNT_W + 5;

  logic [3:0]       r_bright;
  logic [3:0]       w_bright;
  logic             w_latch;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [W_W-1:0]   w_width;

  // A slot starts on the OFF exit or on the advancing terminal cycle.
  assign w_latch   = i_en & ((r_state == OFF) | ((r_state == ON) & w_tc));
  // Brightness in force for the upcoming cycle, including the slot's first one.
  assign w_bright  = w_latch ? i_bright : r_bright;
  assign w_cnt_nxt = (w_clr || w_tc) ? '0 : w_cnt + 1'b1;
  assign w_width   = (W_W'(DIV - DEAD_CYCLES) * (W_W'(w_bright) + W_W'(1))) >> 4;
  assign w_lit     = (W_W'(w_cnt_nxt) - W_W'(DEAD_CYCLES)) < w_width;

  // Hold brightness constant for the whole slot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bright <= 4'hF;
    end else if (w_latch) begin
      r_bright <= i_bright;
    end
  end
`else
  assign w_lit = 1'b1;
`endif

  // Next-state, digit advance and tick generation.
  always_comb begin
    w_state_nxt = r_state;
    w_ctrl_nxt  = r_ctrl;
    w_tick_nxt  = 1'b0;
    if (!i_en) begin
      w_state_nxt = OFF;
    end else begin
      case (r_state)
        OFF: begin
          if (DEAD_CYCLES == 0) w_state_nxt = ON;
          else                  w_state_nxt = DEAD;
        end
        DEAD: begin
          if (w_cnt == C_DEAD_LAST) w_state_nxt = ON;
        end
        ON: begin
          if (w_tc) begin
            w_ctrl_nxt = r_ctrl + 2'd1;
            w_tick_nxt = 1'b1;
            if (DEAD_CYCLES == 0) w_state_nxt = ON;
            else                  w_state_nxt = DEAD;
          end
        end
        default: w_state_nxt = OFF;
      endcase
    end
  end

  // Anode decode from next state so the anodes line up with the state register.
  always_comb begin
    w_anode_nxt = ANODE_ALL_OFF;
    if ((w_state_nxt == ON) && !i_blank_mask[w_ctrl_nxt] && w_lit) begin
      w_anode_nxt[w_ctrl_nxt] = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= OFF;
      r_ctrl    <= '0;
      r_anode_n <= ANODE_ALL_OFF;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ctrl    <= w_ctrl_nxt;
      r_anode_n <= w_anode_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  assign o_ctrl    = r_ctrl;
  assign o_anode_n = r_anode_n;
  assign o_tick    = r_tick;

endmodule

`default_nettype wire
